// File: rtl/led_fader_pkg.sv
// Shared types for the multi-channel LED fader: channel routing modes and
// ramp direction.
package led_fader_pkg;

  // Channel routing modes; encoding 3 is reserved and never stored.
  typedef enum logic [1:0] {
    MODE_SEQ    = 2'd0,
    MODE_ALL    = 2'd1,
    MODE_STATIC = 2'd2
  } mode_e;

  localparam logic [1:0] MODE_RESERVED = 2'd3;

  // Direction of the triangle brightness ramp.
  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // True for encodings that map onto a real mode.
  function automatic logic mode_is_valid(input logic [1:0] m);
    return m != MODE_RESERVED;
  endfunction

endpackage

// File: rtl/breath_ramp.sv
// Triangle ("breathing") brightness generator. Steps once per step_i strobe,
// rising to MAX and falling back to 0 with saturation at both ends.
// level_o is the level that will hold after the current clock edge, so the
// caller can latch it on the same edge that advances the ramp.
module breath_ramp
  import led_fader_pkg::*;
#(
  parameter int MAX  = 46875,
  parameter int STEP = 183,
  localparam int LW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          step_i,
  input  logic          freeze_i,
  input  logic          clear_i,
  output logic [LW-1:0] level_o,
  output logic          at_zero_o
);

  // One extra bit of headroom so level+STEP cannot wrap before the clamp.
  localparam logic [LW:0] MAX_W  = MAX[LW:0];
  localparam logic [LW:0] STEP_W = (STEP > MAX) ? MAX[LW:0] : STEP[LW:0];

  logic [LW-1:0] level_q, level_d;
  dir_e          dir_q, dir_d;
  logic [LW:0]   level_ext;
  logic [LW:0]   level_sum;
  logic [LW:0]   level_diff;
  logic          advance;

  assign advance    = step_i && !freeze_i;
  assign level_ext  = {1'b0, level_q};
  assign level_sum  = level_ext + STEP_W;
  assign level_diff = level_ext - STEP_W;

  // A descending step that lands on zero marks the end of one breath.
  assign at_zero_o = advance && (dir_q == DIR_DOWN) && (level_ext <= STEP_W);
  assign level_o   = level_d;

  // Next level/direction: clear wins, otherwise one saturating step per strobe.
  always_comb begin
    level_d = level_q;
    dir_d   = dir_q;
    if (clear_i) begin
      level_d = '0;
      dir_d   = DIR_UP;
    end else if (advance) begin
      if (dir_q == DIR_UP) begin
        if (level_sum >= MAX_W) begin
          level_d = MAX_W[LW-1:0];
          dir_d   = DIR_DOWN;
        end else begin
          level_d = level_sum[LW-1:0];
        end
      end else begin
        if (level_ext <= STEP_W) begin
          level_d = '0;
          dir_d   = DIR_UP;
        end else begin
          level_d = level_diff[LW-1:0];
        end
      end
    end
  end

  // Ramp state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      level_q <= '0;
      dir_q   <= DIR_UP;
    end else begin
      level_q <= level_d;
      dir_q   <= dir_d;
    end
  end

endmodule

// File: rtl/multi_channel_led_fader.sv
// N-channel PWM LED fader. One shared frame counter, one breathing ramp, and
// per-channel duty registers that only change on the last clock of a frame so
// no output ever sees a partial or doubled pulse. Configuration is captured
// into a shadow copy and takes effect at the next frame boundary.
module multi_channel_led_fader
  import led_fader_pkg::*;
#(
  parameter int    NUM_CH       = 3,
  parameter int    PWM_PERIOD   = 46875,
  parameter int    STEP         = 183,
  parameter bit    ACTIVE_LOW   = 1'b1,
  parameter mode_e DEFAULT_MODE = MODE_SEQ,
  localparam int   DW           = $clog2(PWM_PERIOD + 1),
  localparam int   CW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable_i,
  input  logic              cfg_we_i,
  input  logic [1:0]        cfg_mode_i,
  input  logic [NUM_CH-1:0] cfg_chan_mask_i,
  input  logic [DW-1:0]     cfg_static_duty_i,
  output logic              cfg_pending_o,
  output logic              frame_end_o,
  output logic              breath_end_o,
  output logic [CW-1:0]     active_ch_o,
  output logic [NUM_CH-1:0] led_o
);

  localparam logic [DW-1:0]     LAST_CNT = DW'(PWM_PERIOD - 1);
  localparam logic [DW-1:0]     PERIOD_W = DW'(PWM_PERIOD);
  localparam logic [NUM_CH-1:0] LED_OFF  = {NUM_CH{ACTIVE_LOW}};

  // Next set mask bit above cur, wrapping; cur itself if it is the only one.
  function automatic logic [CW-1:0] next_ch(input logic [NUM_CH-1:0] m,
                                            input logic [CW-1:0]     cur);
    logic [CW-1:0] r;
    int            idx;
    r = cur;
    for (int k = NUM_CH - 1; k >= 1; k--) begin
      idx = (int'(cur) + k) % NUM_CH;
      if (m[idx]) r = CW'(idx);
    end
    return r;
  endfunction

  // Lowest set mask bit (zero when the mask is empty).
  function automatic logic [CW-1:0] lowest_ch(input logic [NUM_CH-1:0] m);
    logic [CW-1:0] r;
    r = '0;
    for (int k = NUM_CH - 1; k >= 0; k--) begin
      if (m[k]) r = CW'(k);
    end
    return r;
  endfunction

  logic [DW-1:0]     cnt_q, cnt_d;
  mode_e             mode_q, mode_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [DW-1:0]     static_q, static_d;
  mode_e             shadow_mode_q;
  logic [NUM_CH-1:0] shadow_mask_q;
  logic [DW-1:0]     shadow_static_q;
  logic              pending_q, pending_d;
  logic [CW-1:0]     active_q, active_d;
  logic [CW-1:0]     active_adv;
  logic [NUM_CH-1:0] led_q;
  logic [NUM_CH-1:0] pwm_raw;

  logic              frame_end;
  logic              apply;
  logic              cfg_accept;
  logic [DW-1:0]     static_in;
  logic              ramp_clear;
  logic [DW-1:0]     level_next;
  logic              breath_end;

  assign frame_end  = enable_i && (cnt_q == LAST_CNT);
  assign apply      = frame_end && pending_q;
  assign cfg_accept = cfg_we_i && mode_is_valid(cfg_mode_i);
  assign static_in  = (cfg_static_duty_i > PERIOD_W) ? PERIOD_W : cfg_static_duty_i;
  assign ramp_clear = apply && (shadow_mode_q != mode_q);

  assign mode_d   = apply ? shadow_mode_q   : mode_q;
  assign mask_d   = apply ? shadow_mask_q   : mask_q;
  assign static_d = apply ? shadow_static_q : static_q;

  breath_ramp #(
    .MAX  (PWM_PERIOD),
    .STEP (STEP)
  ) u_ramp (
    .clk       (clk),
    .reset     (reset),
    .step_i    (frame_end),
    .freeze_i  (mode_q == MODE_STATIC),
    .clear_i   (ramp_clear),
    .level_o   (level_next),
    .at_zero_o (breath_end)
  );

  // Frame counter advances only while enabled and wraps at the period.
  always_comb begin
    cnt_d = cnt_q;
    if (enable_i) begin
      cnt_d = frame_end ? '0 : cnt_q + DW'(1);
    end
  end

  // Pending flag: a fresh valid write always wins over a same-cycle apply.
  always_comb begin
    pending_d = pending_q;
    if (cfg_accept) begin
      pending_d = 1'b1;
    end else if (apply) begin
      pending_d = 1'b0;
    end
  end

  // Channel rotation at breath end, then re-home if the new mask excludes it.
  always_comb begin
    active_adv = active_q;
    if (breath_end && (mode_q == MODE_SEQ) && (|mask_q)) begin
      active_adv = next_ch(mask_q, active_q);
    end
    active_d = active_adv;
    if (apply && (shadow_mode_q == MODE_SEQ) && (|shadow_mask_q) &&
        !shadow_mask_q[active_adv]) begin
      active_d = lowest_ch(shadow_mask_q);
    end
  end

  // Control and configuration registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q           <= '0;
      mode_q          <= DEFAULT_MODE;
      mask_q          <= '1;
      static_q        <= '0;
      shadow_mode_q   <= DEFAULT_MODE;
      shadow_mask_q   <= '1;
      shadow_static_q <= '0;
      pending_q       <= 1'b0;
      active_q        <= '0;
    end else begin
      cnt_q     <= cnt_d;
      mode_q    <= mode_d;
      mask_q    <= mask_d;
      static_q  <= static_d;
      pending_q <= pending_d;
      active_q  <= active_d;
      if (cfg_accept) begin
        shadow_mode_q   <= mode_e'(cfg_mode_i);
        shadow_mask_q   <= cfg_chan_mask_i;
        shadow_static_q <= static_in;
      end
    end
  end

  // Per-channel duty: the target is computed from post-boundary state so the
  // frame that follows shows the level the ramp has just moved to.
  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
    logic [DW-1:0] duty_q, duty_d;

    // Routing of ramp level / static duty to this channel.
    always_comb begin
      duty_d = '0;
      if (mask_d[gi]) begin
        case (mode_d)
          MODE_SEQ:    if (active_d == CW'(gi)) duty_d = level_next;
          MODE_ALL:    duty_d = level_next;
          MODE_STATIC: duty_d = static_d;
          default:     duty_d = '0;
        endcase
      end
    end

    // Duty only changes on the frame boundary.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        duty_q <= '0;
      end else if (frame_end) begin
        duty_q <= duty_d;
      end
    end

    assign pwm_raw[gi] = (cnt_q < duty_q);
  end

  // Registered LED drive; disabled means dark on the very next cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led_q <= LED_OFF;
    end else begin
      led_q <= enable_i ? (pwm_raw ^ LED_OFF) : LED_OFF;
    end
  end

  assign cfg_pending_o = pending_q;
  assign frame_end_o   = frame_end;
  assign breath_end_o  = breath_end;
  assign active_ch_o   = active_q;
  assign led_o         = led_q;

endmodule
